mtm_alu_deserializer: RTL and testbench



---
 rtl/mtm_alu_deserializer.sv | 188 ++++++++++++++++++
 tb/tb_mtm_alu_deserializer.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mtm_alu_deserializer.sv
// rtl/mtm_alu_deserializer.sv - serial frame deserializer feeding the mtm_Alu core
module mtm_alu_deserializer #(
  parameter int         DATA_FRAMES = 8,
  parameter logic [3:0] CRC_POLY    = 4'h3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sin,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [31:0] out_a,
  output logic [31:0] out_b,
  output logic [2:0]  out_op,
  output logic        out_crc_ok,
  output logic        out_err_data,
  output logic        out_err_op,
  output logic        frame_err,
  output logic        overrun
);

  localparam int CW = $clog2(DATA_FRAMES + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(DATA_FRAMES);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DATA_FRAMES + 1);

  typedef enum logic [1:0] {S_IDLE, S_TYPE, S_PAYLOAD, S_STOP} state_t;

  state_t         state;
  state_t         state_nx;
  logic [2:0]     bit_cnt;
  logic [7:0]     pay;
  logic           is_cmd;
  logic           armed;
  logic [CW-1:0]  frame_cnt;
  logic [63:0]    shreg;
  logic [3:0]     crc;

  logic           start_ok;
  logic           data_done;
  logic           cmd_done;
  logic           bad_stop;

  logic [2:0]     cmd_op;
  logic [3:0]     cmd_crc;
  logic [3:0]     crc_final;
  logic           pkt_crc_ok;
  logic           pkt_err_data;
  logic           pkt_err_op;

  // One CRC4 step, MSB-first serial LFSR.
  function automatic logic [3:0] crc_bit(input logic [3:0] c, input logic b);
    logic fb;
    fb = c[3] ^ b;
    return {c[2:0], 1'b0} ^ (fb ? CRC_POLY : 4'h0);
  endfunction

  // Fold a whole data byte into the CRC, MSB first.
  function automatic logic [3:0] crc_byte(input logic [3:0] c, input logic [7:0] d);
    logic [3:0] r;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      r = crc_bit(r, d[i]);
    end
    return r;
  endfunction

  // Fold the CMD tail {1'b1, op} into the CRC.
  function automatic logic [3:0] crc_tail(input logic [3:0] c, input logic [2:0] op);
    logic [3:0] r;
    r = crc_bit(c, 1'b1);
    r = crc_bit(r, op[2]);
    r = crc_bit(r, op[1]);
    r = crc_bit(r, op[0]);
    return r;
  endfunction

  // Frame FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Frame FSM next-state: start, type, 8 payload bits, stop.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:    if (!sin && armed) state_nx = S_TYPE;
      S_TYPE:    state_nx = S_PAYLOAD;
      S_PAYLOAD: if (bit_cnt == 3'd7) state_nx = S_STOP;
      S_STOP:    state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  // Frame FSM outputs: frame-level events decoded from the stop bit.
  always_comb begin
    start_ok  = 1'b0;
    data_done = 1'b0;
    cmd_done  = 1'b0;
    bad_stop  = 1'b0;
    case (state)
      S_IDLE: start_ok = !sin && armed;
      S_STOP: begin
        data_done = sin && !is_cmd;
        cmd_done  = sin && is_cmd;
        bad_stop  = !sin;
      end
      default: ;
    endcase
  end

  // Bit-level capture: type bit, payload shifter, and the re-arm guard after a bad stop.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt <= 3'd0;
      pay     <= 8'd0;
      is_cmd  <= 1'b0;
      armed   <= 1'b0;
    end else begin
      if (state == S_IDLE && sin) armed <= 1'b1;
      if (bad_stop) armed <= 1'b0;
      if (state == S_TYPE) begin
        is_cmd  <= sin;
        bit_cnt <= 3'd0;
      end
      if (state == S_PAYLOAD) begin
        pay     <= {pay[6:0], sin};
        bit_cnt <= bit_cnt + 3'd1;
      end
    end
  end

  // Packet accumulator: operand shift register, frame counter and running CRC.
  always_ff @(posedge clk) begin
    if (rst || bad_stop || cmd_done) begin
      frame_cnt <= '0;
      shreg     <= 64'd0;
      crc       <= 4'd0;
    end else if (data_done) begin
      shreg     <= {shreg[55:0], pay};
      crc       <= crc_byte(crc, pay);
      frame_cnt <= (frame_cnt == CNT_MAX) ? frame_cnt : frame_cnt + CW'(1);
    end
  end

  // Packet verdicts evaluated while the CMD stop bit is being sampled.
  always_comb begin
    cmd_op       = pay[6:4];
    cmd_crc      = pay[3:0];
    crc_final    = crc_tail(crc, cmd_op);
    pkt_crc_ok   = (crc_final == cmd_crc);
    pkt_err_data = (frame_cnt != CNT_FULL);
    pkt_err_op   = !(cmd_op inside {3'b000, 3'b001, 3'b100, 3'b101});
  end

  // Output holding register with valid/ready handshake and overrun/frame-error pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_a        <= 32'd0;
      out_b        <= 32'd0;
      out_op       <= 3'd0;
      out_crc_ok   <= 1'b0;
      out_err_data <= 1'b0;
      out_err_op   <= 1'b0;
      frame_err    <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      frame_err <= bad_stop;
      overrun   <= 1'b0;
      if (cmd_done && (!out_valid || out_ready)) begin
        out_valid    <= 1'b1;
        out_b        <= shreg[63:32];
        out_a        <= shreg[31:0];
        out_op       <= cmd_op;
        out_crc_ok   <= pkt_crc_ok;
        out_err_data <= pkt_err_data;
        out_err_op   <= pkt_err_op;
      end else begin
        if (cmd_done) overrun <= 1'b1;
        if (out_valid && out_ready) out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mtm_alu_deserializer.sv
// tb/tb_mtm_alu_deserializer.sv - scoreboard bench for mtm_alu_deserializer
module tb_mtm_alu_deserializer;

  logic        clk = 1'b0;
  logic        rst;
  logic        sin;
  logic        out_ready;
  logic        out_valid;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic [2:0]  out_op;
  logic        out_crc_ok;
  logic        out_err_data;
  logic        out_err_op;
  logic        frame_err;
  logic        overrun;

  always #5 clk = ~clk;

  mtm_alu_deserializer dut (
    .clk          (clk),
    .rst          (rst),
    .sin          (sin),
    .out_ready    (out_ready),
    .out_valid    (out_valid),
    .out_a        (out_a),
    .out_b        (out_b),
    .out_op       (out_op),
    .out_crc_ok   (out_crc_ok),
    .out_err_data (out_err_data),
    .out_err_op   (out_err_op),
    .frame_err    (frame_err),
    .overrun      (overrun)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic        crc_ok;
    logic        err_data;
    logic        err_op;
    bit          chk_ops;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_ferr = 0;
  int   n_ovr = 0;
  int   ready_mode = 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // CRC4 over the 68-bit message {B, A, 1, op}, bit by bit from the MSB.
  function automatic logic [3:0] ref_crc(input logic [31:0] b, input logic [31:0] a, input logic [2:0] op);
    logic [67:0] v;
    logic [3:0]  c;
    logic        fb;
    v = {b, a, 1'b1, op};
    c = 4'h0;
    for (int i = 67; i >= 0; i--) begin
      fb = c[3] ^ v[i];
      c  = {c[2:0], 1'b0} ^ (fb ? 4'h3 : 4'h0);
    end
    return c;
  endfunction

  function automatic logic ref_err_op(input logic [2:0] op);
    return !(op == 3'b000 || op == 3'b001 || op == 3'b100 || op == 3'b101);
  endfunction

  // out_ready driver: low, high or random per cycle.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (ready_mode == 2) out_ready = 1'($urandom_range(0, 1));
      else out_ready = (ready_mode == 1);
    end
  end

  // Monitor: pops the scoreboard on each transfer, checks holding and pulse widths.
  initial begin
    logic        p_hold = 1'b0;
    logic        p_ferr = 1'b0;
    logic        p_ovr = 1'b0;
    logic [69:0] p_out = '0;
    exp_t        e;
    forever begin
      @(negedge clk);
      #1;
      if (frame_err) begin
        n_ferr++;
        chk("frame_err_width", p_ferr, 1'b0);
      end
      if (overrun) begin
        n_ovr++;
        chk("overrun_width", p_ovr, 1'b0);
      end
      if (p_hold)
        chk("hold_stable", {out_a, out_b, out_op, out_crc_ok, out_err_data, out_err_op}, p_out);
      if (out_valid && out_ready && !rst) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", out_valid, 1'b0);
        end else begin
          e = exp_q.pop_front();
          chk("out_op", out_op, e.op);
          chk("out_err_data", out_err_data, e.err_data);
          chk("out_err_op", out_err_op, e.err_op);
          if (e.chk_ops) begin
            chk("out_a", out_a, e.a);
            chk("out_b", out_b, e.b);
            chk("out_crc_ok", out_crc_ok, e.crc_ok);
          end
        end
      end
      p_hold = out_valid && !out_ready && !rst;
      p_out  = {out_a, out_b, out_op, out_crc_ok, out_err_data, out_err_op};
      p_ferr = frame_err;
      p_ovr  = overrun;
    end
  end

  task automatic send_bit(input logic b);
    @(negedge clk);
    sin = b;
  endtask

  task automatic idle(input int n);
    repeat (n) send_bit(1'b1);
  endtask

  task automatic send_frame(input logic t, input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    send_bit(t);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    send_bit(stop);
  endtask

  // n data frames (B bytes then A bytes, extras random), then CMD {0, op, crcf}.
  task automatic send_packet(input int n, input logic [63:0] ba, input logic [2:0] op,
                             input logic [3:0] crcf, input bit push);
    exp_t e;
    logic [7:0] d;
    if (push) begin
      e.b        = ba[63:32];
      e.a        = ba[31:0];
      e.op       = op;
      e.err_data = (n != 8);
      e.err_op   = ref_err_op(op);
      e.crc_ok   = (crcf == ref_crc(ba[63:32], ba[31:0], op));
      e.chk_ops  = (n == 8);
      exp_q.push_back(e);
    end
    for (int i = 0; i < n; i++) begin
      d = (i < 8) ? ba[63 - 8*i -: 8] : 8'($urandom);
      send_frame(1'b0, d, 1'b1);
      idle($urandom_range(0, 2));
    end
    send_frame(1'b1, {1'b0, op, crcf}, 1'b1);
  endtask

  task automatic good_packet(input int n, input logic [2:0] op, input bit push);
    logic [63:0] ba;
    ba = {$urandom, $urandom};
    send_packet(n, ba, op, ref_crc(ba[63:32], ba[31:0], op), push);
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      send_bit(1'b1);
      t++;
    end
    idle(3);
    chk(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_valid"}, out_valid, 1'b0);
    chk({tag, "_a"}, out_a, 32'd0);
    chk({tag, "_b"}, out_b, 32'd0);
    chk({tag, "_op"}, out_op, 3'd0);
    chk({tag, "_crc_ok"}, out_crc_ok, 1'b0);
    chk({tag, "_err_data"}, out_err_data, 1'b0);
    chk({tag, "_err_op"}, out_err_op, 1'b0);
    chk({tag, "_frame_err"}, frame_err, 1'b0);
    chk({tag, "_overrun"}, overrun, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] ba;
    logic [3:0]  cr;
    logic [2:0]  op;
    int          f0;
    int          o0;
    int          n;
    logic        seen;

    rst = 1'b1;
    sin = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk_zero_outputs("reset");
    rst = 1'b0;
    idle(3);

    // All-zero packet with literal CRC 0xB; one-cycle out_valid.
    send_packet(8, 64'd0, 3'b000, 4'hB, 1);
    send_bit(1'b1);
    #1;
    chk("t1_valid_rise", out_valid, 1'b1);
    send_bit(1'b1);
    #1;
    chk("t1_valid_fall", out_valid, 1'b0);
    drain("t1_drain");

    // Small operands with model CRC, then with CRC bit 0 flipped.
    ba = {32'h1, 32'h2};
    cr = ref_crc(32'h1, 32'h2, 3'b100);
    send_packet(8, ba, 3'b100, cr, 1);
    send_packet(8, ba, 3'b100, cr ^ 4'h1, 1);
    drain("t2_drain");

    // Frame count errors, then recovery.
    good_packet(7, 3'b001, 1);
    good_packet(9, 3'b101, 1);
    good_packet(8, 3'b000, 1);
    drain("t3_drain");

    // Every opcode value.
    for (int o = 0; o < 8; o++) good_packet(8, 3'(o), 1);
    drain("t4_drain");

    // Bad stop mid-packet; line stays low briefly before re-arming.
    f0 = n_ferr;
    send_frame(1'b0, 8'($urandom), 1'b1);
    send_frame(1'b0, 8'($urandom), 1'b1);
    send_frame(1'b0, 8'($urandom), 1'b1);
    send_frame(1'b0, 8'($urandom), 1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    idle(3);
    chk("t5_frame_err_count", n_ferr - f0, 1);
    good_packet(8, 3'b100, 1);
    drain("t5_drain");

    // Overrun: packet 1 held, packet 2 dropped.
    ready_mode = 0;
    idle(2);
    good_packet(8, 3'b101, 1);
    idle(3);
    o0 = n_ovr;
    good_packet(8, 3'b001, 0);
    idle(3);
    chk("t6_overrun_count", n_ovr - o0, 1);
    chk("t6_still_valid", out_valid, 1'b1);
    ready_mode = 1;
    drain("t6_drain");

    // Reset during frame 4 while a held packet is pending.
    ready_mode = 0;
    idle(2);
    good_packet(8, 3'b000, 0);
    idle(2);
    chk("t7_pre_reset_valid", out_valid, 1'b1);
    for (int i = 0; i < 3; i++) send_frame(1'b0, 8'($urandom), 1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    @(negedge clk);
    rst = 1'b1;
    sin = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_zero_outputs("t7_after_rst");
    seen = 1'b0;
    repeat (30) begin
      send_bit(1'b1);
      #1;
      if (out_valid) seen = 1'b1;
    end
    chk("t7_no_spurious_valid", seen, 1'b0);
    ready_mode = 1;
    good_packet(8, 3'b100, 1);
    drain("t7_drain");

    // Randomized packets with random backpressure.
    ready_mode = 2;
    for (int k = 0; k < 12; k++) begin
      n  = ($urandom_range(0, 5) == 0) ? (($urandom_range(0, 1) == 0) ? 7 : 9) : 8;
      op = 3'($urandom_range(0, 7));
      ba = {$urandom, $urandom};
      cr = ref_crc(ba[63:32], ba[31:0], op);
      if ($urandom_range(0, 3) == 0) cr = cr ^ 4'($urandom_range(1, 15));
      send_packet(n, ba, op, cr, 1);
      idle($urandom_range(0, 3));
    end
    ready_mode = 1;
    drain("rand_drain");

    chk("frame_err_total", n_ferr, 1);
    chk("overrun_total", n_ovr, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
